// File: rtl/sha1_block_padder.sv
// rtl/sha1_block_padder.sv - SHA-1 message padder turning a byte stream into 512-bit blocks
// Optional status_word output is enabled by defining SHA1_PADDER_STATUS_EN.
module sha1_block_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_keep,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_final,
    output logic [1:0]   state
`ifdef SHA1_PADDER_STATUS_EN
    ,
    output logic [31:0]  status_word
`endif
);

    typedef enum logic [1:0] {
        S_FILL  = 2'b00,
        S_EMIT  = 2'b01,
        S_EXTRA = 2'b10
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_blk_valid;
    logic             r_blk_first;
    logic             r_blk_final;
    logic             r_extra_pend;
    logic             r_extra_mark;
    logic [511:0]     r_blk;
    logic [5:0]       r_bi;
    logic [LEN_W-1:0] r_len;

    logic             w_accept;
    logic             w_handshake;
    logic [LEN_W-1:0] w_len_next;
    logic [63:0]      w_len64;
    logic [63:0]      w_len64_cur;
    int               w_n;
    logic [511:0]     w_cur;
    logic [511:0]     w_pad;
    logic [511:0]     w_extra;

    assign w_accept    = (r_state == S_FILL) && r_in_ready && in_valid;
    assign w_handshake = r_blk_valid && blk_ready;
    assign w_len_next  = in_keep ? r_len + LEN_W'(8) : r_len;
    assign w_len64     = 64'(w_len_next);
    assign w_len64_cur = 64'(r_len);
    assign w_n         = int'(r_bi) + (in_keep ? 1 : 0);

    // w_n counts the bytes of the closing block including the beat being accepted
    always_comb begin
        w_cur = r_blk;
        if (in_keep) w_cur[(63 - int'(r_bi)) * 8 +: 8] = in_data;
        w_pad = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < w_n)       w_pad[(63 - i) * 8 +: 8] = w_cur[(63 - i) * 8 +: 8];
            else if (i == w_n) w_pad[(63 - i) * 8 +: 8] = 8'h80;
        end
        if (w_n <= 55) w_pad[63:0] = w_len64;
    end

    // Marker lands in the extra block only when the message ended exactly on a block boundary
    assign w_extra = {(r_extra_mark ? 8'h80 : 8'h00), 440'd0, w_len64_cur};

`ifdef SHA1_PADDER_STATUS_EN
    logic [15:0] r_cnt;
    assign status_word = {14'd0, r_state, r_cnt};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_FILL;
            r_in_ready   <= 1'b0;
            r_blk_valid  <= 1'b0;
            r_blk_first  <= 1'b1;
            r_blk_final  <= 1'b0;
            r_extra_pend <= 1'b0;
            r_extra_mark <= 1'b0;
            r_blk        <= '0;
            r_bi         <= '0;
            r_len        <= '0;
`ifdef SHA1_PADDER_STATUS_EN
            r_cnt        <= '0;
`endif
        end else begin
            case (r_state)
                S_FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (in_keep) r_len <= w_len_next;
                        if (in_last) begin
                            r_blk        <= w_pad;
                            r_bi         <= '0;
                            r_in_ready   <= 1'b0;
                            r_blk_valid  <= 1'b1;
                            r_blk_final  <= (w_n <= 55);
                            r_extra_pend <= (w_n > 55);
                            r_extra_mark <= (w_n == 64);
                            r_state      <= S_EMIT;
                        end else if (in_keep) begin
                            r_blk <= w_cur;
                            if (r_bi == 6'd63) begin
                                r_bi         <= '0;
                                r_in_ready   <= 1'b0;
                                r_blk_valid  <= 1'b1;
                                r_blk_final  <= 1'b0;
                                r_extra_pend <= 1'b0;
                                r_state      <= S_EMIT;
                            end else begin
                                r_bi <= r_bi + 6'd1;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    if (w_handshake) begin
`ifdef SHA1_PADDER_STATUS_EN
                        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
`endif
                        if (r_extra_pend) begin
                            r_blk        <= w_extra;
                            r_blk_first  <= 1'b0;
                            r_blk_final  <= 1'b1;
                            r_extra_pend <= 1'b0;
                            r_state      <= S_EXTRA;
                        end else begin
                            r_blk_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_blk_final <= 1'b0;
                            r_blk_first <= r_blk_final;
                            r_state     <= S_FILL;
                            if (r_blk_final) begin
                                r_len <= '0;
`ifdef SHA1_PADDER_STATUS_EN
                                r_cnt <= '0;
`endif
                            end
                        end
                    end
                end
                S_EXTRA: begin
                    if (w_handshake) begin
                        r_blk_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_blk_first <= 1'b1;
                        r_blk_final <= 1'b0;
                        r_len       <= '0;
                        r_state     <= S_FILL;
`ifdef SHA1_PADDER_STATUS_EN
                        r_cnt       <= '0;
`endif
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign blk_valid = r_blk_valid;
    assign blk_data  = r_blk;
    assign blk_first = r_blk_first;
    assign blk_final = r_blk_final;
    assign state     = r_state;

endmodule

// File: tb/tb_sha1_block_padder.sv
// tb/tb_sha1_block_padder.sv - scoreboard bench for sha1_block_padder
module tb_sha1_block_padder;

    typedef logic [7:0] u8;
    typedef struct {
        logic [511:0] d;
        logic         f;
        logic         fi;
    } blk_t;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'd0};
    localparam logic [511:0] X56_BLK   = {480'd0, 32'h000001C0};
    localparam logic [511:0] X64_BLK   = {32'h80000000, 448'd0, 32'h00000200};

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_keep;
    logic         in_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_final;
    logic [1:0]   state;
`ifdef SHA1_PADDER_STATUS_EN
    logic [31:0]  status_word;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   tmo      = 1'b0;
    blk_t exp_q[$];

    sha1_block_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_final (blk_final),
        .state     (state)
`ifdef SHA1_PADDER_STATUS_EN
        ,
        .status_word (status_word)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length
    task automatic model_push(input u8 msg[$]);
        u8           p[$];
        logic [63:0] bl;
        blk_t        b;
        int          nb;
        p  = msg;
        bl = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[i * 8 +: 8]);
        nb = p.size() / 64;
        for (int k = 0; k < nb; k++) begin
            for (int i = 0; i < 64; i++) b.d[(63 - i) * 8 +: 8] = p[k * 64 + i];
            b.f  = (k == 0);
            b.fi = (k == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) tmo = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_msg(input u8 msg[$]);
        model_push(msg);
        if (msg.size() == 0) send_beat(8'h00, 1'b0, 1'b1);
        else for (int i = 0; i < msg.size(); i++) send_beat(msg[i], 1'b1, i == msg.size() - 1);
    endtask

    task automatic get_block(output logic [511:0] d, output logic f, output logic fi,
                             output logic ir, output int gap, output bit ok);
        d = '0; f = 1'b0; fi = 1'b0; ir = 1'b0; gap = 0; ok = 1'b1;
        while (blk_valid !== 1'b1) begin
            if (gap >= 200) begin
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            gap++;
        end
        d = blk_data; f = blk_first; fi = blk_final; ir = in_ready;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
        in_data = 8'h00; blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, blk_valid, blk_first, blk_final, state} !== 6'b001000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 001000",
                     {in_ready, blk_valid, blk_first, blk_final, state});
        end
        n_checks++;
        if (blk_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", blk_data);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: in_ready %b state %b expected 1 00", in_ready, state);
        end
    endtask

    task automatic test_abc_empty();
        u8 m[$]; blk_t e; logic [511:0] d; logic f, fi, ir; int gap; bit ok;
        blk_ready = 1'b1;
        exp_q.delete();
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m);
        get_block(d, f, fi, ir, gap, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || d !== e.d || d !== ABC_BLK) begin
            n_fail++;
            $display("FAIL abc_data: got %h expected %h", d, ABC_BLK);
        end
        n_checks++;
        if ({f, fi} !== {e.f, e.fi} || {f, fi} !== 2'b11) begin
            n_fail++;
            $display("FAIL abc_flags: got %b expected 11", {f, fi});
        end
        m = {};
        send_msg(m);
        get_block(d, f, fi, ir, gap, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || d !== e.d || d !== EMPTY_BLK) begin
            n_fail++;
            $display("FAIL empty_data: got %h expected %h", d, EMPTY_BLK);
        end
        n_checks++;
        if ({f, fi} !== 2'b11) begin
            n_fail++;
            $display("FAIL empty_flags: got %b expected 11", {f, fi});
        end
    endtask

    task automatic test_two_block();
        u8 m[$]; blk_t e1, e2; logic [511:0] d1, d2; logic f1, fi1, ir1, f2, fi2, ir2;
        int g1, g2; bit ok1, ok2;
        blk_ready = 1'b1;
        exp_q.delete();
        m = {};
        for (int i = 0; i < 56; i++) m.push_back(u8'(i + 1));
        send_msg(m);
        get_block(d1, f1, fi1, ir1, g1, ok1);
        get_block(d2, f2, fi2, ir2, g2, ok2);
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_checks++;
        if (!ok1 || d1 !== e1.d || {f1, fi1} !== 2'b10) begin
            n_fail++;
            $display("FAIL m56_blk1: got %h/%b expected %h/10", d1, {f1, fi1}, e1.d);
        end
        n_checks++;
        if (!ok2 || d2 !== e2.d || d2 !== X56_BLK || {f2, fi2} !== 2'b01) begin
            n_fail++;
            $display("FAIL m56_blk2: got %h/%b expected %h/01", d2, {f2, fi2}, X56_BLK);
        end
        n_checks++;
        if (g2 !== 0) begin
            n_fail++;
            $display("FAIL m56_gap: got %0d idle cycles expected 0", g2);
        end
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(u8'($urandom));
        send_msg(m);
        get_block(d1, f1, fi1, ir1, g1, ok1);
        get_block(d2, f2, fi2, ir2, g2, ok2);
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_checks++;
        if (!ok1 || d1 !== e1.d || {f1, fi1} !== 2'b10) begin
            n_fail++;
            $display("FAIL m64_blk1: got %h/%b expected %h/10", d1, {f1, fi1}, e1.d);
        end
        n_checks++;
        if (!ok2 || d2 !== e2.d || d2 !== X64_BLK || {f2, fi2} !== 2'b01) begin
            n_fail++;
            $display("FAIL m64_blk2: got %h/%b expected %h/01", d2, {f2, fi2}, X64_BLK);
        end
        n_checks++;
        if ({ir1, ir2} !== 2'b00) begin
            n_fail++;
            $display("FAIL m64_in_ready: got %b expected 00", {ir1, ir2});
        end
    endtask

    task automatic test_stall();
        u8 m[$]; blk_t e; logic [511:0] d; logic f, fi, ir; int gap, t; bit ok;
        blk_ready = 1'b0;
        exp_q.delete();
        m = {};
        for (int i = 0; i < 10; i++) m.push_back(u8'($urandom));
        send_msg(m);
        e = exp_q.pop_front();
        t = 0;
        while (blk_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1'b1; in_data = 8'hEE; in_keep = 1'b1; in_last = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (blk_data !== e.d || {blk_valid, blk_first, blk_final, in_ready, state} !== {1'b1, e.f, e.fi, 1'b0, 2'b01}) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: data %h flags %b expected %h %b", c, blk_data,
                         {blk_valid, blk_first, blk_final, in_ready, state}, e.d, {1'b1, e.f, e.fi, 1'b0, 2'b01});
            end
        end
        in_valid = 1'b0; in_keep = 1'b0;
        blk_ready = 1'b1;
        @(negedge clk);
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m);
        get_block(d, f, fi, ir, gap, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || d !== e.d || d !== ABC_BLK || {f, fi} !== 2'b11) begin
            n_fail++;
            $display("FAIL stall_next_msg: got %h/%b expected %h/11", d, {f, fi}, ABC_BLK);
        end
    endtask

    task automatic test_reset_mid();
        u8 m[$]; blk_t e; logic [511:0] d; logic f, fi, ir; int gap; bit ok;
        blk_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 30; i++) send_beat(u8'($urandom), 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, blk_valid, blk_first, blk_final, state} !== 6'b001000 || blk_data !== '0) begin
            n_fail++;
            $display("FAIL midreset_values: flags %b data %h expected 001000 and 0",
                     {in_ready, blk_valid, blk_first, blk_final, state}, blk_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m);
        get_block(d, f, fi, ir, gap, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || d !== e.d || d !== ABC_BLK || {f, fi} !== 2'b11) begin
            n_fail++;
            $display("FAIL midreset_abc: got %h/%b expected %h/11", d, {f, fi}, ABC_BLK);
        end
    endtask

    task automatic test_back_to_back();
        int lens[6] = '{55, 57, 63, 1, 64, 0};
        int nblk = 0;
        blk_ready = 1'b1;
        exp_q.delete();
        foreach (lens[i]) nblk += (lens[i] + 9 + 63) / 64;
        fork
            begin
                u8 m[$];
                for (int k = 0; k < 6; k++) begin
                    m = {};
                    for (int i = 0; i < lens[k]; i++) m.push_back(u8'($urandom));
                    send_msg(m);
                end
            end
            begin
                blk_t e; logic [511:0] d; logic f, fi, ir; int gap; bit ok;
                for (int b = 0; b < nblk; b++) begin
                    get_block(d, f, fi, ir, gap, ok);
                    n_checks++;
                    if (!ok || exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL b2b_block %0d: no block or no expectation (ok %0d)", b, ok);
                        break;
                    end
                    e = exp_q.pop_front();
                    if (d !== e.d || {f, fi} !== {e.f, e.fi}) begin
                        n_fail++;
                        $display("FAIL b2b_block %0d: got %h/%b expected %h/%b", b, d, {f, fi}, e.d, {e.f, e.fi});
                    end
                end
            end
        join
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_leftover: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_abc_empty();
        test_two_block();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL input_timeout: got %b expected 0", tmo);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha1_block_padder.md
# sha1_block_padder

Front-end feeder for the SHA-1 state-machine core: accepts a message as a byte stream, applies SHA-1 padding (0x80 marker, zero fill, 64-bit big-endian bit length), and presents complete 512-bit blocks to the core with a valid/ready handshake. It is the writer side of the core's `writedata` block interface and produces the first/final block flags that drive the core's configuration words. One message is in flight at a time; blocks leave in message order.

## Interface
- `LEN_W`, 64, width of the internal bit-length counter (≤64); zero-extended into the 64-bit length field; wraps modulo 2^LEN_W.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_data`  in  8  message byte.
- `in_keep`  in  1  beat carries a byte; 0 is legal only with `in_last`=1 (empty tail, incl. zero-length message).
- `in_last`  in  1  beat ends the message.
- `blk_valid`  out  1  `blk_data` holds a complete block.
- `blk_ready`  in  1  core accepts the block (start).
- `blk_data`  out  512  block; word 0 = bits [511:480], first message byte = bits [511:504].
- `blk_first`  out  1  block is first of its message (core loads initial H).
- `blk_final`  out  1  block is last of its message (digest valid after it).
- `state`  out  2  00 FILL, 01 EMIT, 10 EXTRA, 11 unused.

## Operation
- FILL: `in_ready`=1. Accepted beat with `in_keep`=1 writes `in_data` at byte index `bi` (0..63), `bi`++, bit length += 8.
- Accepted beat with `in_last`=0 that fills byte 63 → EMIT (data block, `blk_final`=0), `bi`←0.
- Accepted beat with `in_last`=1 (after its byte, if any), let n = bytes in block:
  - n ≤ 55: byte n = 0x80, bytes n+1..55 = 0, bytes 56..63 = length → EMIT, `blk_final`=1.
  - 56 ≤ n ≤ 63: byte n = 0x80, rest 0 → EMIT, `blk_final`=0, pending extra block = zeros + length.
  - n = 64: block unchanged → EMIT, `blk_final`=0, pending extra block = 0x80, zeros, length.
- EMIT: `blk_valid`=1; on `blk_valid && blk_ready`: if extra block pending → EXTRA, else → FILL (and, if final, clear length and set first-flag for next message).
- EXTRA: `blk_valid`=1 with pending block, `blk_first`=0, `blk_final`=1; on handshake → FILL, length cleared.
- `blk_first`=1 only on the first block emitted after reset or after a final block.
- Length field = bit count, big-endian in bytes 56..63 (words 14–15).

## Timing
- Reset values: `in_ready`=0, `blk_valid`=0, `blk_data`=0, `blk_first`=1, `blk_final`=0, `state`=00, length=0, `bi`=0; any partial block is discarded.
- `in_ready` is registered; it rises on the first clock edge after `reset_n` deasserts. It falls the cycle after a block-completing or last beat and rises the cycle after the handshake that returns the block to FILL.
- Block latency: `blk_valid` rises on the edge that accepts the completing or last beat and is visible the next cycle.
- EXTRA `blk_valid` is visible the cycle after the EMIT handshake, with no bubble.
- `blk_data`, `blk_first` and `blk_final` are stable while `blk_valid`=1 and `blk_ready`=0.
- `in_valid` outside FILL is ignored; nothing is lost because `in_ready`=0.
- `blk_ready` without `blk_valid` has no effect.
- Throughput: 1 byte/cycle, plus at least 1 cycle per block handshake.
- Asynchronous reset mid-message or mid-handshake aborts immediately and forces the reset values.

## Configuration
- `SHA1_PADDER_STATUS_EN` defined: adds output `status_word` [31:0], registered:
  - [15:0] = blocks emitted for the current message, saturating at 0xFFFF, cleared after final handshake.
  - [17:16] = `state`.
  - [31:18] = 0.
  - Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- "abc" (0x61,0x62,0x63 with `in_last` on 0x63), `blk_ready`=1 → single block with word0=0x61626380, words1–14=0, word15=0x00000018, `blk_first`=`blk_final`=1.
- Zero-length message (one beat, `in_keep`=0, `in_last`=1) → word0=0x80000000, all other words 0, `blk_first`=`blk_final`=1.
- 56-byte message → block1 has byte 56=0x80 and `blk_final`=0; EXTRA block is all zeros except word15=0x000001C0 with `blk_final`=1; the two blocks are back to back when `blk_ready`=1.
- 64-byte message → block1 is raw data; block2 has word0=0x80000000 and word15=0x00000200; `in_ready` is low across both blocks.
- `blk_ready` held 0 for 10 cycles in EMIT → `blk_data` and flags stay constant and `in_ready`=0; a 2nd message started after the handshake has `blk_first`=1 and a length counted from 0.
- `reset_n` pulsed low after 30 bytes → all outputs take their reset values; a following "abc" yields the first-scenario block exactly.
